packet_router_dispatch: RTL

Packet dispatcher for the packet router. It accepts one AXI-Stream input and inspects the destination field of each packet's first beat. It forwards the whole packet to output 0 or output 1, or drops it, and maintains the three 32-bit statistics counters read over AXI-Lite by `packet_router_regbank`.

---
 rtl/packet_router_pkg.sv | 32 +++
 rtl/packet_router_counter.sv | 34 +++
 rtl/packet_router_dispatch.sv | 135 +++++++++++++
 3 files changed

// File: rtl/packet_router_pkg.sv
// ---------------------------------------------------------------------------
// packet_router_pkg
// Shared types and constants for the packet router.
//   dispatch_state_t : dispatcher FSM state (IDLE, FWD0, FWD1, DROP)
//   DEST_OUT0/1      : destination codes that select output 0 / output 1
//   CNT_W            : statistics counter width (also used by the regbank)
//   dest_to_state()  : maps a destination code to the forwarding state
// ---------------------------------------------------------------------------
package packet_router_pkg;

   localparam int CNT_W = 32;

   localparam logic [1:0] DEST_OUT0 = 2'd0;
   localparam logic [1:0] DEST_OUT1 = 2'd1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD0 = 2'd1,
      FWD1 = 2'd2,
      DROP = 2'd3
   } dispatch_state_t;

   // Any code other than the two output codes is a drop.
   function automatic dispatch_state_t dest_to_state(input logic [1:0] dest);
      case (dest)
         DEST_OUT0: dest_to_state = FWD0;
         DEST_OUT1: dest_to_state = FWD1;
         default:   dest_to_state = DROP;
      endcase
   endfunction

endpackage

// File: rtl/packet_router_counter.sv
// ---------------------------------------------------------------------------
// packet_router_counter
// CNT_W-bit wrapping statistics counter.
//   clk    : clock
//   resetn : synchronous active-low reset, clears the count
//   inc    : add one this cycle (wraps modulo 2^CNT_W)
//   clear  : set the count to zero; takes priority over inc
//   count  : current count
// ---------------------------------------------------------------------------
module packet_router_counter
   import packet_router_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (inc) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/packet_router_dispatch.sv
// ---------------------------------------------------------------------------
// packet_router_dispatch
// Routes each AXI-Stream packet to output 0, output 1 or the bin, based on
// the 2-bit destination field of its first beat, and counts completed
// packets per outcome.
//   clk, resetn            : clock, synchronous active-low reset
//   s_axis_*               : input stream (tdata, tvalid, tready, tlast)
//   m0_axis_* / m1_axis_*  : output streams (tdata, tvalid, tready, tlast)
//   num_packets_sent_to_output_0/1, num_packets_dropped : statistics
//   clear_counters         : synchronous counter clear, only present when
//                            PACKET_ROUTER_DISPATCH_CLEAR_EN is defined
// Parameters: DATA_W (stream width), DEST_LSB (LSB of destination field).
// ---------------------------------------------------------------------------
module packet_router_dispatch
   import packet_router_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEST_LSB = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   output logic [DATA_W-1:0] m0_axis_tdata,
   output logic              m0_axis_tvalid,
   input  logic              m0_axis_tready,
   output logic              m0_axis_tlast,
   output logic [DATA_W-1:0] m1_axis_tdata,
   output logic              m1_axis_tvalid,
   input  logic              m1_axis_tready,
   output logic              m1_axis_tlast,
   output logic [CNT_W-1:0]  num_packets_sent_to_output_0,
   output logic [CNT_W-1:0]  num_packets_sent_to_output_1,
   output logic [CNT_W-1:0]  num_packets_dropped
`ifdef PACKET_ROUTER_DISPATCH_CLEAR_EN
   ,
   input  logic              clear_counters
`endif
);

   dispatch_state_t state_reg;
   dispatch_state_t state_next;
   logic [1:0]      dest;
   logic            pkt_end;
   logic            clr;

   assign dest = s_axis_tdata[DEST_LSB+1:DEST_LSB];

`ifdef PACKET_ROUTER_DISPATCH_CLEAR_EN
   assign clr = clear_counters;
`else
   assign clr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Outputs default to all-zero so that IDLE (and reset) present clean
   // idle buses; the FWD states pass the input straight through.
   always_comb begin
      state_next     = state_reg;
      s_axis_tready  = 1'b0;
      m0_axis_tdata  = '0;
      m0_axis_tvalid = 1'b0;
      m0_axis_tlast  = 1'b0;
      m1_axis_tdata  = '0;
      m1_axis_tvalid = 1'b0;
      m1_axis_tlast  = 1'b0;
      case (state_reg)
         IDLE: begin
            // First beat stays upstream; it is consumed from the FWD/DROP state.
            if (s_axis_tvalid) begin
               state_next = dest_to_state(dest);
            end
         end
         FWD0: begin
            m0_axis_tdata  = s_axis_tdata;
            m0_axis_tvalid = s_axis_tvalid;
            m0_axis_tlast  = s_axis_tlast;
            s_axis_tready  = m0_axis_tready;
         end
         FWD1: begin
            m1_axis_tdata  = s_axis_tdata;
            m1_axis_tvalid = s_axis_tvalid;
            m1_axis_tlast  = s_axis_tlast;
            s_axis_tready  = m1_axis_tready;
         end
         DROP: begin
            s_axis_tready = 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // s_axis_tready is only ever high outside IDLE, so this fires only at
      // the end of a packet being forwarded or dropped.
      if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
         state_next = IDLE;
      end
   end

   assign pkt_end = s_axis_tvalid & s_axis_tready & s_axis_tlast;

   packet_router_counter u_cnt_out0 (
      .clk    (clk),
      .resetn (resetn),
      .inc    (pkt_end && (state_reg == FWD0)),
      .clear  (clr),
      .count  (num_packets_sent_to_output_0)
   );

   packet_router_counter u_cnt_out1 (
      .clk    (clk),
      .resetn (resetn),
      .inc    (pkt_end && (state_reg == FWD1)),
      .clear  (clr),
      .count  (num_packets_sent_to_output_1)
   );

   packet_router_counter u_cnt_drop (
      .clk    (clk),
      .resetn (resetn),
      .inc    (pkt_end && (state_reg == DROP)),
      .clear  (clr),
      .count  (num_packets_dropped)
   );

endmodule
